// File: rtl/udp_tx.sv
// Ethernet II / IPv4 / UDP frame builder: wraps a FWFT payload stream with preamble,
// headers, IPv4 checksum, zero padding and CRC-32 FCS, one byte per serializer slot.
module udp_tx #(
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int unsigned IFG_BYTES   = 12,
    parameter logic [10:0] MAX_PAYLOAD = 11'd1472
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] payload_len,
    input  logic [47:0] src_mac,
    input  logic [47:0] dst_mac,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [7:0]  payload_d,
    output logic        payload_rd,
    input  logic        eth_byte_en,
    output logic [7:0]  eth_d,
    output logic        eth_dv,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    localparam int unsigned CNT_W    = 11;
    localparam logic [CNT_W-1:0] MIN_DATA = 11'd18;
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR,
        S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [47:0]       dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
    logic [31:0]       src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    logic [15:0]       src_port_q, src_port_d, dst_port_q, dst_port_d;
    logic [15:0]       ident_q, ident_d;
    logic [31:0]       crc_q, crc_d;
    logic [7:0]        eth_d_q, eth_d_d;
    logic              eth_dv_q, eth_dv_d;
    logic              busy_q, busy_d, done_q, done_d, len_err_q, len_err_d;

    // Reflected CRC-32 (poly 0x04C11DB7), data bits consumed LSB first as on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] r;
        r = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [15:0]  total_len_c, udp_len_c, csum_c;
    logic [19:0]  csum_acc_c, csum_fold_c;
    logic [111:0] eth_hdr_c, eth_sh_c;
    logic [159:0] ip_hdr_c, ip_sh_c;
    logic [63:0]  udp_hdr_c, udp_sh_c;
    logic [31:0]  fcs_c, fcs_sh_c;

    assign total_len_c = 16'(len_q) + 16'd28;
    assign udp_len_c   = 16'(len_q) + 16'd8;

    // Header fields are frozen for the whole frame, so the checksum settles long before its slot.
    assign csum_acc_c  = 20'h04500 + 20'(total_len_c) + 20'(ident_q) + 20'h04000
                       + 20'({TTL, 8'h11}) + 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0])
                       + 20'(dst_ip_q[31:16]) + 20'(dst_ip_q[15:0]);
    assign csum_fold_c = 20'(csum_acc_c[15:0]) + 20'(csum_acc_c[19:16]);
    assign csum_c      = ~(csum_fold_c[15:0] + 16'(csum_fold_c[19:16]));

    assign eth_hdr_c = {dst_mac_q, src_mac_q, 16'h0800};
    assign ip_hdr_c  = {8'h45, 8'h00, total_len_c, ident_q, 16'h4000, TTL, 8'h11, csum_c,
                        src_ip_q, dst_ip_q};
    assign udp_hdr_c = {src_port_q, dst_port_q, udp_len_c, 16'h0000};
    assign fcs_c     = ~crc_q;

    assign eth_sh_c = eth_hdr_c << {cnt_q[3:0], 3'b000};
    assign ip_sh_c  = ip_hdr_c  << {cnt_q[4:0], 3'b000};
    assign udp_sh_c = udp_hdr_c << {cnt_q[2:0], 3'b000};
    assign fcs_sh_c = fcs_c     >> {cnt_q[1:0], 3'b000};

    // Next-state, field latching and byte selection.
    always_comb begin
        logic [7:0] tx_byte;
        logic       tx_dv;
        logic       crc_en;
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dst_mac_d  = dst_mac_q;
        src_mac_d  = src_mac_q;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        ident_d    = ident_q;
        crc_d      = crc_q;
        eth_d_d    = eth_d_q;
        eth_dv_d   = eth_dv_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        len_err_d  = 1'b0;
        tx_byte    = 8'h00;
        tx_dv      = 1'b1;
        crc_en     = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                if (payload_len != 11'd0 && payload_len <= MAX_PAYLOAD) begin
                    state_d    = S_PREAMBLE;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    len_d      = payload_len;
                    dst_mac_d  = dst_mac;
                    src_mac_d  = src_mac;
                    src_ip_d   = src_ip;
                    dst_ip_d   = dst_ip;
                    src_port_d = src_port;
                    dst_port_d = dst_port;
                end else begin
                    len_err_d = 1'b1;
                end
            end
        end else if (eth_byte_en) begin
            cnt_d = cnt_q + 11'd1;
            unique case (state_q)
                S_PREAMBLE: begin
                    tx_byte = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
                    crc_d   = 32'hFFFF_FFFF;
                    if (cnt_q == 11'd7) begin state_d = S_ETH_HDR; cnt_d = '0; end
                end
                S_ETH_HDR: begin
                    tx_byte = eth_sh_c[111:104];
                    crc_en  = 1'b1;
                    if (cnt_q == 11'd13) begin state_d = S_IP_HDR; cnt_d = '0; end
                end
                S_IP_HDR: begin
                    tx_byte = ip_sh_c[159:152];
                    crc_en  = 1'b1;
                    if (cnt_q == 11'd19) begin state_d = S_UDP_HDR; cnt_d = '0; end
                end
                S_UDP_HDR: begin
                    tx_byte = udp_sh_c[63:56];
                    crc_en  = 1'b1;
                    if (cnt_q == 11'd7) begin state_d = S_PAYLOAD; cnt_d = '0; end
                end
                S_PAYLOAD: begin
                    tx_byte = payload_d;
                    crc_en  = 1'b1;
                    if (cnt_q == len_q - 11'd1) begin
                        state_d = (len_q < MIN_DATA) ? S_PAD : S_FCS;
                        cnt_d   = '0;
                    end
                end
                S_PAD: begin
                    crc_en = 1'b1;
                    if (cnt_q == MIN_DATA - 11'd1 - len_q) begin state_d = S_FCS; cnt_d = '0; end
                end
                S_FCS: begin
                    tx_byte = fcs_sh_c[7:0];
                    if (cnt_q == 11'd3) begin
                        state_d = S_IFG;
                        cnt_d   = '0;
                        ident_d = ident_q + 16'd1;
                    end
                end
                S_IFG: begin
                    tx_dv = 1'b0;
                    if (cnt_q == IFG_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (crc_en) crc_d = crc32_byte(crc_q, tx_byte);
            eth_d_d  = tx_byte;
            eth_dv_d = tx_dv;
        end
    end

    // State and datapath registers.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            dst_mac_q  <= '0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            ident_q    <= '0;
            crc_q      <= '1;
            eth_d_q    <= '0;
            eth_dv_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            dst_mac_q  <= dst_mac_d;
            src_mac_q  <= src_mac_d;
            src_ip_q   <= src_ip_d;
            dst_ip_q   <= dst_ip_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            ident_q    <= ident_d;
            crc_q      <= crc_d;
            eth_d_q    <= eth_d_d;
            eth_dv_q   <= eth_dv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_err_q  <= len_err_d;
        end
    end

    assign payload_rd = eth_byte_en & (state_q == S_PAYLOAD);
    assign eth_d      = eth_d_q;
    assign eth_dv     = eth_dv_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_udp_tx.sv
// Directed bench for udp_tx: captures every strobed frame byte and checks it against
// an independently built reference frame plus hand-computed header constants.
module tb_udp_tx;

    logic        c = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] payload_len;
    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port;
    logic [7:0]  payload_d;
    logic        payload_rd;
    logic        eth_byte_en;
    logic [7:0]  eth_d;
    logic        eth_dv, busy, done, len_err;

    udp_tx dut (
        .c(c), .rst_n(rst_n), .start(start), .payload_len(payload_len),
        .src_mac(src_mac), .dst_mac(dst_mac), .src_ip(src_ip), .dst_ip(dst_ip),
        .src_port(src_port), .dst_port(dst_port), .payload_d(payload_d),
        .payload_rd(payload_rd), .eth_byte_en(eth_byte_en), .eth_d(eth_d),
        .eth_dv(eth_dv), .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 c = ~c;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pay [0:1499];
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    int rd_cnt, ifg_cnt, hold_err, lerr_cnt, pidx;
    logic [10:0] cur_len;
    logic [15:0] cur_sport;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void push_be(input logic [63:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(8'(v >> (8 * i)));
    endfunction

    function automatic logic [15:0] ref_csum(input logic [15:0] tl, input logic [15:0] id);
        int s;
        s = 32'h4500 + int'(tl) + int'(id) + 32'h4000 + 32'h4011
          + int'(src_ip[31:16]) + int'(src_ip[15:0]) + int'(dst_ip[31:16]) + int'(dst_ip[15:0]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~16'(s);
    endfunction

    function automatic logic [31:0] ref_crc(input logic [7:0] q[$], input int from);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        for (int i = from; i < q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                if (r[0] ^ q[i][b]) r = (r >> 1) ^ 32'hEDB88320;
                else                r = r >> 1;
            end
        end
        return r;
    endfunction

    function automatic void build_exp(input int len, input logic [15:0] id);
        logic [31:0] fcs;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be(64'(dst_mac), 6);
        push_be(64'(src_mac), 6);
        push_be(64'h0800, 2);
        push_be(64'h4500, 2);
        push_be(64'(len + 28), 2);
        push_be(64'(id), 2);
        push_be(64'h4000, 2);
        push_be(64'h4011, 2);
        push_be(64'(ref_csum(16'(len + 28), id)), 2);
        push_be(64'(src_ip), 4);
        push_be(64'(dst_ip), 4);
        push_be(64'(src_port), 2);
        push_be(64'(dst_port), 2);
        push_be(64'(len + 8), 2);
        push_be(64'h0, 2);
        for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
        while (exp_q.size() < 68) exp_q.push_back(8'h00);
        fcs = ~ref_crc(exp_q, 8);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(fcs >> (8 * i)));
    endfunction

    task automatic cmp_frame(input string tag, input int len, input logic [15:0] id);
        int nmis;
        build_exp(len, id);
        chk({tag, "_size"}, 32'(rx.size()), 32'(exp_q.size()));
        nmis = 0;
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
            if (rx[i] !== exp_q[i]) nmis++;
        chk({tag, "_bytes"}, 32'(nmis), 32'd0);
        // Running the CRC across data plus FCS must leave the 802.3 residue.
        chk({tag, "_residue"}, ref_crc(rx, 8), 32'hDEBB20E3);
    endtask

    task automatic do_start(input logic [10:0] len);
        @(negedge c);
        eth_byte_en = 1'b0;
        payload_len = len;
        cur_len     = len;
        start       = 1'b1;
        @(negedge c);
        start = 1'b0;
    endtask

    task automatic run_frame(input int pace, input int busy_start_cyc, input int abort_at_rd,
                             output bit got_done);
        logic [7:0] prev_d;
        logic       prev_dv;
        rx.delete();
        rd_cnt = 0; ifg_cnt = 0; hold_err = 0; lerr_cnt = 0; pidx = 0;
        got_done = 1'b0;
        prev_d  = eth_d;
        prev_dv = eth_dv;
        for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
            @(negedge c);
            start       = (cyc == busy_start_cyc);
            payload_len = (cyc == busy_start_cyc) ? 11'd5 : cur_len;
            src_port    = (cyc == busy_start_cyc) ? 16'hDEAD : cur_sport;
            eth_byte_en = ((cyc % pace) == 0);
            payload_d   = pay[pidx];
            #1;
            if (payload_rd) begin
                rd_cnt++;
                pidx++;
                if (abort_at_rd != 0 && rd_cnt == abort_at_rd) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_dv", 32'(eth_dv), 32'd0);
                    chk("abort_rd", 32'(payload_rd), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    @(negedge c);
                    rst_n       = 1'b1;
                    eth_byte_en = 1'b0;
                    return;
                end
            end
            @(posedge c);
            #1;
            if (len_err) lerr_cnt++;
            if (eth_byte_en) begin
                if (eth_dv) rx.push_back(eth_d);
                else if (rx.size() != 0) ifg_cnt++;
            end else if (eth_d !== prev_d || eth_dv !== prev_dv) begin
                hold_err++;
            end
            prev_d  = eth_d;
            prev_dv = eth_dv;
            if (done) got_done = 1'b1;
        end
        @(negedge c);
        eth_byte_en = 1'b0;
        start       = 1'b0;
        src_port    = cur_sport;
    endtask

    task automatic reject_test(input string tag, input logic [10:0] len);
        int bad;
        do_start(len);
        chk({tag, "_lenerr"}, 32'(len_err), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge c);
            eth_byte_en = 1'b1;
            if (eth_dv || busy || len_err) bad++;
        end
        eth_byte_en = 1'b0;
        chk({tag, "_quiet"}, 32'(bad), 32'd0);
    endtask

    initial begin
        bit ok;
        int zeros;
        for (int i = 0; i < 1500; i++) pay[i] = 8'(i * 7 + 3);
        rst_n       = 1'b0;
        start       = 1'b0;
        eth_byte_en = 1'b0;
        payload_d   = 8'h00;
        payload_len = 11'd0;
        dst_mac     = 48'h02_00_00_00_00_02;
        src_mac     = 48'h02_00_00_00_00_01;
        src_ip      = 32'hC0A8_010A;
        dst_ip      = 32'hC0A8_0114;
        cur_sport   = 16'h1234;
        src_port    = cur_sport;
        dst_port    = 16'h5678;
        cur_len     = 11'd0;

        // Reset state
        repeat (2) @(negedge c);
        #1;
        chk("rst_eth_d", 32'(eth_d), 32'd0);
        chk("rst_eth_dv", 32'(eth_dv), 32'd0);
        chk("rst_payload_rd", 32'(payload_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        @(negedge c);
        rst_n = 1'b1;

        // Frame A: 4-byte payload, continuous strobe, ident 0
        do_start(11'd4);
        chk("A_busy_acc", 32'(busy), 32'd1);
        run_frame(1, -1, 0, ok);
        chk("A_done", 32'(ok), 32'd1);
        chk("A_len72", 32'(rx.size()), 32'd72);
        chk("A_total_len", 32'({rx[24], rx[25]}), 32'h0020);
        chk("A_udp_len", 32'({rx[46], rx[47]}), 32'h000C);
        chk("A_ip_csum", 32'({rx[32], rx[33]}), 32'hB75E);
        chk("A_ident", 32'({rx[26], rx[27]}), 32'h0000);
        chk("A_payload", 32'({rx[50], rx[51], rx[52], rx[53]}),
            32'({pay[0], pay[1], pay[2], pay[3]}));
        zeros = 0;
        for (int i = 54; i < 68; i++) if (rx[i] == 8'h00) zeros++;
        chk("A_pad14", 32'(zeros), 32'd14);
        chk("A_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("A_ifg", 32'(ifg_cnt), 32'd12);
        chk("A_busy_end", 32'(busy), 32'd0);
        cmp_frame("A", 4, 16'h0000);

        // Frame B: maximum payload, ident 1
        do_start(11'd1472);
        run_frame(1, -1, 0, ok);
        chk("B_done", 32'(ok), 32'd1);
        chk("B_len1526", 32'(rx.size()), 32'd1526);
        chk("B_rd_cnt", 32'(rd_cnt), 32'd1472);
        chk("B_ident", 32'({rx[26], rx[27]}), 32'h0001);
        cmp_frame("B", 1472, 16'h0001);

        // Out-of-range lengths are rejected
        reject_test("len0", 11'd0);
        reject_test("len1473", 11'd1473);

        // Frame C: RMII 1-in-4 pacing, 18-byte payload
        do_start(11'd18);
        run_frame(4, -1, 0, ok);
        chk("C_done", 32'(ok), 32'd1);
        chk("C_hold", 32'(hold_err), 32'd0);
        chk("C_rd_cnt", 32'(rd_cnt), 32'd18);
        cmp_frame("C", 18, 16'h0002);

        // Frames D/E: start while busy ignored, next start after done accepted
        do_start(11'd30);
        run_frame(1, 40, 0, ok);
        chk("D_done", 32'(ok), 32'd1);
        chk("D_no_lenerr", 32'(lerr_cnt), 32'd0);
        cmp_frame("D", 30, 16'h0003);
        do_start(11'd6);
        run_frame(1, -1, 0, ok);
        chk("E_done", 32'(ok), 32'd1);
        chk("E_ident", 32'({rx[26], rx[27]}), 32'h0004);
        cmp_frame("E", 6, 16'h0004);

        // Frame F aborted by reset mid-payload; frame G restarts ident at 0
        do_start(11'd100);
        run_frame(1, -1, 10, ok);
        do_start(11'd20);
        run_frame(1, -1, 0, ok);
        chk("G_done", 32'(ok), 32'd1);
        chk("G_ident", 32'({rx[26], rx[27]}), 32'h0000);
        cmp_frame("G", 20, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udp_tx.md
Name: udp_tx

Overview:
- Transmit-side counterpart of the UDP receive path. Builds a complete Ethernet II / IPv4 / UDP frame around a payload pulled from a first-word-fall-through byte source.
- Frame content: preamble + SFD, all headers, IPv4 header checksum, zero padding to minimum frame size, and CRC-32 FCS.
- Emits one byte per byte slot toward the MII/RMII serializer, then enforces the interframe gap.

Parameters:
- TTL, 8'd64, IPv4 time-to-live field.
- IFG_BYTES, 12, idle byte slots after the FCS before the next frame may start.
- MAX_PAYLOAD, 11'd1472, largest accepted UDP payload length in bytes.

Ports:
- c  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a frame when idle
- payload_len  in  11  UDP payload byte count, sampled on accepted start
- src_mac  in  48  source MAC, sampled on accepted start
- dst_mac  in  48  destination MAC, sampled on accepted start
- src_ip  in  32  source IPv4 address, sampled on accepted start
- dst_ip  in  32  destination IPv4 address, sampled on accepted start
- src_port  in  16  UDP source port, sampled on accepted start
- dst_port  in  16  UDP destination port, sampled on accepted start
- payload_d  in  8  payload byte; FWFT, valid whenever it is being popped
- payload_rd  out  1  pop strobe; asserted in the cycle payload_d is consumed
- eth_byte_en  in  1  byte-slot strobe from the serializer
- eth_d  out  8  frame byte
- eth_dv  out  1  frame byte valid
- busy  out  1  high from accepted start through end of IFG
- done  out  1  one-cycle pulse when IFG completes
- len_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: eth_d=0, eth_dv=0, payload_rd=0, busy=0, done=0, len_err=0. IP identification counter resets to 0. Reset asserted mid-frame drops eth_dv immediately (asynchronous clear); no partial frame resumes.
- Start handling:
  - Accepted only in IDLE with 1 <= payload_len <= MAX_PAYLOAD. All header inputs are latched and busy=1 on the next edge.
  - Start with an out-of-range length pulses len_err one cycle later and stays in IDLE.
  - Start while busy is ignored (no len_err).
- Byte-slot rules:
  - All frame progress (state, counters, CRC, payload_rd) advances only in cycles with eth_byte_en=1.
  - eth_d and eth_dv update on the edge ending an eth_byte_en cycle and hold otherwise.
  - payload_rd = eth_byte_en & (state==PAYLOAD).
- States, in order, with byte counts:
  - IDLE.
  - PREAMBLE: 7x 0x55, then 0xD5.
  - ETH_HDR (14): dst_mac, src_mac (MS byte first), ethertype 0x0800.
  - IP_HDR (20): 0x45, 0x00; total_len = payload_len+28; ident; 0x40,0x00 (DF set, offset 0); TTL; 0x11; checksum; src_ip; dst_ip.
  - UDP_HDR (8): src_port, dst_port, udp_len = payload_len+8, checksum 0x0000.
  - PAYLOAD (payload_len).
  - PAD: zeros while payload_len < 18, count 18-payload_len, so header+payload+pad = 60.
  - FCS (4).
  - IFG (IFG_BYTES slots, eth_dv=0).
  - Back to IDLE, pulsing done.
- Field widths and arithmetic:
  - Multi-byte fields are sent big-endian.
  - total_len and udp_len are 16-bit, zero-extended from payload_len.
- IPv4 checksum:
  - One's-complement sum of the ten header words with the checksum word as 0. Use a 20-bit accumulator, fold the carries twice, then invert.
  - Must be final before the checksum byte slot. Computing it during PREAMBLE/ETH_HDR (at least 22 slots) is sufficient; a multi-cycle computation is allowed.
- IP identification: ident is the current counter value; the counter increments by 1 (wrapping 0xFFFF->0) when FCS completes.
- FCS:
  - IEEE 802.3 CRC-32 over ETH_HDR through PAD; preamble/SFD excluded. Reuse eth_crc32.
  - Transmitted complemented, least-significant byte first, bit order per 802.3.
- eth_dv is high exactly from the first preamble byte through the last FCS byte.
- Latency: first preamble byte appears on eth_d after the first eth_byte_en following an accepted start.

Test Plan:
- Length 4, eth_byte_en=1 continuous, known MACs/IPs/ports:
  - Frame is 8+60+4 bytes, with 14 zero pad bytes.
  - total_len=0x0020, udp_len=0x000C.
  - Checksum matches a software model.
  - Looping into udp_rx yields udp_last with the 4 bytes intact.
- Length 1472:
  - 1526 bytes with eth_dv high.
  - payload_rd high for exactly 1472 cycles.
  - No padding.
  - FCS matches the software CRC-32.
- start with payload_len=0, and separately with 1473 -> len_err pulse, busy stays 0, eth_dv never rises.
- eth_byte_en asserted 1-in-4 (RMII 100M pacing), length 18 -> byte sequence identical to the continuous case; eth_d changes only after strobed cycles.
- Two back-to-back frames:
  - Second start during busy is ignored; second start after done is accepted.
  - ident increments 0x0000->0x0001.
  - At least 12 strobed idle slots between frames.
- rst_n pulled low mid-PAYLOAD -> eth_dv/payload_rd/busy drop immediately, ident resets to 0, and the next frame is complete and correct.
